cc_regbank_demux: RTL and testbench

- Write-side counterpart of the register-bank read multiplexer: takes the 4-bit destination code and the data bus, and writes the value into one of 14 architectural registers (g0..g7, PC, Temp0..Temp3, IR).
- Holds those registers and exposes all 14 as parallel outputs that feed the read mux.
- Also provides PC auto-increment, a one-cycle write acknowledge and a sticky illegal-destination flag.

---
 rtl/cc_regbank_pkg.sv | 24 ++
 rtl/cc_regbank_wrdecode.sv | 22 ++
 rtl/cc_regbank_demux.sv | 100 ++++++++++
 tb/tb_cc_regbank_demux.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cc_regbank_pkg.sv
// Shared definitions for the register-bank read mux and write demux, so the
// select encoding and default widths cannot drift between the two.
package cc_regbank_pkg;

    localparam int DEFAULT_SEL_WIDTH = 4;
    localparam int DEFAULT_BUS_WIDTH = 32;
    localparam int NUM_REGS          = 14;

    localparam logic [3:0] SEL_G0    = 4'd0;
    localparam logic [3:0] SEL_G1    = 4'd1;
    localparam logic [3:0] SEL_G2    = 4'd2;
    localparam logic [3:0] SEL_G3    = 4'd3;
    localparam logic [3:0] SEL_G4    = 4'd4;
    localparam logic [3:0] SEL_G5    = 4'd5;
    localparam logic [3:0] SEL_G6    = 4'd6;
    localparam logic [3:0] SEL_G7    = 4'd7;
    localparam logic [3:0] SEL_PC    = 4'd8;
    localparam logic [3:0] SEL_TEMP0 = 4'd9;
    localparam logic [3:0] SEL_TEMP1 = 4'd10;
    localparam logic [3:0] SEL_TEMP2 = 4'd11;
    localparam logic [3:0] SEL_TEMP3 = 4'd12;
    localparam logic [3:0] SEL_IR    = 4'd13;

endpackage

// File: rtl/cc_regbank_wrdecode.sv
// One-hot write-enable decoder: turns a destination code plus write strobe
// into per-register enables, flagging codes beyond the last register.
module cc_regbank_wrdecode
    import cc_regbank_pkg::*;
#(
    parameter int SEL_WIDTH = DEFAULT_SEL_WIDTH
) (
    input  logic [SEL_WIDTH-1:0] selection,
    input  logic                 write,
    output logic [NUM_REGS-1:0]  writeEnable,
    output logic                 illegal
);

    always_comb begin
        writeEnable = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            writeEnable[i] = write && (selection == SEL_WIDTH'(i));
        end
        illegal = write && (selection >= SEL_WIDTH'(NUM_REGS));
    end

endmodule

// File: rtl/cc_regbank_demux.sv
// Write side of the register bank: holds g0..g7, PC, Temp0..Temp3 and IR,
// with PC auto-increment, a write acknowledge and a sticky illegal-code flag.
module cc_regbank_demux
    import cc_regbank_pkg::*;
#(
    parameter int                       DATAWIDTH_DECODER_SELECTION = DEFAULT_SEL_WIDTH,
    parameter int                       DATAWIDTH_BUS               = DEFAULT_BUS_WIDTH,
    parameter logic [DATAWIDTH_BUS-1:0] PC_INCREMENT                = DATAWIDTH_BUS'(4),
    parameter logic [DATAWIDTH_BUS-1:0] PC_RESET_VALUE              = '0
) (
    input  logic                                   CC_REGBANK_CLOCK_50,
    input  logic                                   CC_REGBANK_RESET_InLow,
    input  logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_DataBUS_In,
    input  logic [DATAWIDTH_DECODER_SELECTION-1:0] CC_REGBANK_Selection_In,
    input  logic                                   CC_REGBANK_Write_InHigh,
    input  logic                                   CC_REGBANK_PCInc_InHigh,
    input  logic                                   CC_REGBANK_ErrClr_InHigh,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_g0_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_g1_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_g2_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_g3_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_g4_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_g5_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_g6_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_g7_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_PC_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_Temp0_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_Temp1_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_Temp2_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_Temp3_Out,
    output logic [DATAWIDTH_BUS-1:0]               CC_REGBANK_IR_Out,
    output logic                                   CC_REGBANK_WrAck_OutHigh,
    output logic                                   CC_REGBANK_Err_OutHigh
);

    logic [DATAWIDTH_BUS-1:0] regFile [NUM_REGS];
    logic [NUM_REGS-1:0]      writeEnable;
    logic                     illegalWrite;
    logic                     wrAck;
    logic                     errFlag;

    cc_regbank_wrdecode #(
        .SEL_WIDTH(DATAWIDTH_DECODER_SELECTION)
    ) wrDecode (
        .selection  (CC_REGBANK_Selection_In),
        .write      (CC_REGBANK_Write_InHigh),
        .writeEnable(writeEnable),
        .illegal    (illegalWrite)
    );

    // Write is a single-cycle strobe with no backpressure: every strobe with a
    // legal code commits at that edge and is acknowledged on the next cycle.
    // g0 (index 0) is never written, so it stays at its reset value of zero.
    always_ff @(posedge CC_REGBANK_CLOCK_50 or negedge CC_REGBANK_RESET_InLow) begin
        if (!CC_REGBANK_RESET_InLow) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= '0;
            end
            regFile[SEL_PC] <= PC_RESET_VALUE;
            wrAck           <= 1'b0;
            errFlag         <= 1'b0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (i != int'(SEL_PC) && writeEnable[i]) begin
                    regFile[i] <= CC_REGBANK_DataBUS_In;
                end
            end
            // An explicit PC write takes priority over the increment strobe.
            if (writeEnable[SEL_PC]) begin
                regFile[SEL_PC] <= CC_REGBANK_DataBUS_In;
            end else if (CC_REGBANK_PCInc_InHigh) begin
                regFile[SEL_PC] <= regFile[SEL_PC] + PC_INCREMENT;
            end
            wrAck <= |writeEnable;
            if (illegalWrite) begin
                errFlag <= 1'b1;
            end else if (CC_REGBANK_ErrClr_InHigh) begin
                errFlag <= 1'b0;
            end
        end
    end

    assign CC_REGBANK_g0_Out        = regFile[SEL_G0];
    assign CC_REGBANK_g1_Out        = regFile[SEL_G1];
    assign CC_REGBANK_g2_Out        = regFile[SEL_G2];
    assign CC_REGBANK_g3_Out        = regFile[SEL_G3];
    assign CC_REGBANK_g4_Out        = regFile[SEL_G4];
    assign CC_REGBANK_g5_Out        = regFile[SEL_G5];
    assign CC_REGBANK_g6_Out        = regFile[SEL_G6];
    assign CC_REGBANK_g7_Out        = regFile[SEL_G7];
    assign CC_REGBANK_PC_Out        = regFile[SEL_PC];
    assign CC_REGBANK_Temp0_Out     = regFile[SEL_TEMP0];
    assign CC_REGBANK_Temp1_Out     = regFile[SEL_TEMP1];
    assign CC_REGBANK_Temp2_Out     = regFile[SEL_TEMP2];
    assign CC_REGBANK_Temp3_Out     = regFile[SEL_TEMP3];
    assign CC_REGBANK_IR_Out        = regFile[SEL_IR];
    assign CC_REGBANK_WrAck_OutHigh = wrAck;
    assign CC_REGBANK_Err_OutHigh   = errFlag;

endmodule

// File: tb/tb_cc_regbank_demux.sv
// Directed bench for cc_regbank_demux: every register, PC increment/wrap,
// write/increment priority, g0 protection, sticky error flag and async reset.
module tb_cc_regbank_demux;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] dataBus;
    logic [3:0]  selection;
    logic        write;
    logic        pcInc;
    logic        errClr;
    logic [31:0] g0, g1, g2, g3, g4, g5, g6, g7, pc, temp0, temp1, temp2, temp3, ir;
    logic        wrAck;
    logic        err;

    logic [31:0] expRegs [14];
    logic [31:0] exp_q [$];
    int          assertCount = 0;
    int          failCount   = 0;

    always #10 clk = ~clk;

    cc_regbank_demux dut (
        .CC_REGBANK_CLOCK_50     (clk),
        .CC_REGBANK_RESET_InLow  (rstN),
        .CC_REGBANK_DataBUS_In   (dataBus),
        .CC_REGBANK_Selection_In (selection),
        .CC_REGBANK_Write_InHigh (write),
        .CC_REGBANK_PCInc_InHigh (pcInc),
        .CC_REGBANK_ErrClr_InHigh(errClr),
        .CC_REGBANK_g0_Out       (g0),
        .CC_REGBANK_g1_Out       (g1),
        .CC_REGBANK_g2_Out       (g2),
        .CC_REGBANK_g3_Out       (g3),
        .CC_REGBANK_g4_Out       (g4),
        .CC_REGBANK_g5_Out       (g5),
        .CC_REGBANK_g6_Out       (g6),
        .CC_REGBANK_g7_Out       (g7),
        .CC_REGBANK_PC_Out       (pc),
        .CC_REGBANK_Temp0_Out    (temp0),
        .CC_REGBANK_Temp1_Out    (temp1),
        .CC_REGBANK_Temp2_Out    (temp2),
        .CC_REGBANK_Temp3_Out    (temp3),
        .CC_REGBANK_IR_Out       (ir),
        .CC_REGBANK_WrAck_OutHigh(wrAck),
        .CC_REGBANK_Err_OutHigh  (err)
    );

    // Reference read mux, using the same select codes as the write side.
    function automatic logic [31:0] readMux(input int sel);
        case (sel)
            0:  return g0;
            1:  return g1;
            2:  return g2;
            3:  return g3;
            4:  return g4;
            5:  return g5;
            6:  return g6;
            7:  return g7;
            8:  return pc;
            9:  return temp0;
            10: return temp1;
            11: return temp2;
            12: return temp3;
            13: return ir;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string step, input logic expAck, input logic expErr);
        for (int i = 0; i < 14; i++) begin
            check($sformatf("%s reg%0d", step, i), readMux(i), expRegs[i]);
        end
        check({step, " wrAck"}, {31'd0, wrAck}, {31'd0, expAck});
        check({step, " err"}, {31'd0, err}, {31'd0, expErr});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [3:0] sel, input logic [31:0] d,
                         input logic inc, input logic clr);
        write     = w;
        selection = sel;
        dataBus   = d;
        pcInc     = inc;
        errClr    = clr;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic clearModel();
        for (int i = 0; i < 14; i++) expRegs[i] = 32'd0;
    endtask

    initial begin
        rstN = 1'b0;
        idle();
        clearModel();

        // Reset state
        #5;
        checkAll("in_reset", 1'b0, 1'b0);
        tick();
        checkAll("reset_held", 1'b0, 1'b0);
        rstN = 1'b1;

        // Single write to g3
        drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0);
        tick();
        expRegs[3] = 32'hDEADBEEF;
        checkAll("wr_g3", 1'b1, 1'b0);
        idle();
        tick();
        checkAll("wr_g3_after", 1'b0, 1'b0);

        // g0 stays zero but the write is acknowledged
        drive(1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        tick();
        checkAll("wr_g0", 1'b1, 1'b0);
        idle();
        tick();
        checkAll("wr_g0_after", 1'b0, 1'b0);

        // PC load then three increments; third increment also writes g5
        drive(1'b1, 4'd8, 32'h00000010, 1'b0, 1'b0);
        tick();
        expRegs[8] = 32'h00000010;
        checkAll("pc_load", 1'b1, 1'b0);
        drive(1'b0, 4'd8, 32'hAAAAAAAA, 1'b1, 1'b0);
        tick();
        expRegs[8] = 32'h00000014;
        checkAll("pc_inc1", 1'b0, 1'b0);
        tick();
        expRegs[8] = 32'h00000018;
        checkAll("pc_inc2", 1'b0, 1'b0);
        drive(1'b1, 4'd5, 32'h55AA55AA, 1'b1, 1'b0);
        tick();
        expRegs[8] = 32'h0000001C;
        expRegs[5] = 32'h55AA55AA;
        checkAll("pc_inc3_wr_g5", 1'b1, 1'b0);

        // PC wraps modulo 2^32
        drive(1'b1, 4'd8, 32'hFFFFFFFC, 1'b0, 1'b0);
        tick();
        expRegs[8] = 32'hFFFFFFFC;
        checkAll("pc_load_top", 1'b1, 1'b0);
        drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        tick();
        expRegs[8] = 32'h00000000;
        checkAll("pc_wrap", 1'b0, 1'b0);

        // Write to PC beats increment in the same cycle
        drive(1'b1, 4'd8, 32'h00000400, 1'b1, 1'b0);
        tick();
        expRegs[8] = 32'h00000400;
        checkAll("pc_wr_beats_inc", 1'b1, 1'b0);

        // Selection ignored with Write low
        drive(1'b0, 4'd7, 32'hCAFEF00D, 1'b0, 1'b0);
        tick();
        checkAll("no_write", 1'b0, 1'b0);

        // Illegal destination sets the sticky flag
        drive(1'b1, 4'd14, 32'h12345678, 1'b0, 1'b0);
        tick();
        checkAll("illegal_14", 1'b0, 1'b1);
        idle();
        tick();
        checkAll("err_held", 1'b0, 1'b1);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        tick();
        checkAll("err_clr", 1'b0, 1'b0);
        drive(1'b1, 4'd15, 32'h87654321, 1'b0, 1'b1);
        tick();
        checkAll("illegal_15_with_clr", 1'b0, 1'b1);
        idle();
        tick();
        checkAll("err_held2", 1'b0, 1'b1);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        tick();
        checkAll("err_clr2", 1'b0, 1'b0);

        // Back-to-back sweep of every legal writable code
        for (int c = 1; c <= 13; c++) begin
            drive(1'b1, 4'(c), 32'h100 + 32'(c), 1'b0, 1'b0);
            exp_q.push_back(32'h100 + 32'(c));
            tick();
            expRegs[c] = 32'h100 + 32'(c);
            check($sformatf("sweep wrAck%0d", c), {31'd0, wrAck}, 32'd1);
            check($sformatf("sweep reg%0d", c), readMux(c), exp_q[exp_q.size() - 1]);
        end
        idle();
        tick();
        checkAll("sweep_after", 1'b0, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            check($sformatf("readmux sel%0d", c), readMux(c), exp_q.pop_front());
        end

        // Async reset mid-cycle with a write pending discards the write
        drive(1'b1, 4'd4, 32'h0BADF00D, 1'b1, 1'b0);
        #5;
        rstN = 1'b0;
        #1;
        clearModel();
        checkAll("async_reset", 1'b0, 1'b0);
        tick();
        checkAll("reset_mid_write", 1'b0, 1'b0);
        idle();
        rstN = 1'b1;
        tick();
        checkAll("post_reset", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
